serial_addsub_ctrl: RTL and testbench

Sequencing controller that performs wide add/subtract by time-multiplexing a single 4-bit add/sub nibble slice over `NIBBLES` cycles, least-significant nibble first. It carries between nibbles through a carry register. It sits between a requesting unit and the nibble datapath, trading latency for area. Operand capture, nibble iteration, carry chaining, subtract handling, flag generation and a start/done handshake are all owned here.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_nibble.sv | 30 +++
 rtl/serial_addsub_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial add/subtract controller.
package addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/addsub_nibble.sv
// 4-bit add/subtract slice: s = a + (b ^ {4{m}}) + cin, as four ripple full adders.
// The carry-in is kept separate from m so the caller can chain nibbles.
module addsub_nibble
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                m_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W:0]   c;

  // Ripple-carry chain over the conditionally inverted b operand.
  always_comb begin
    bx   = b_i ^ {NIBBLE_W{m_i}};
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s_o[i]   = a_i[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end
    cout_o = c[NIBBLE_W];
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Wide add/subtract done one nibble per cycle, LSB nibble first, through a single
// addsub_nibble slice. Operands are captured on start; result/flags are valid on done.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          op_i,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a_i,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b_i,
  output logic                          ready_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NIBBLE_W*NIBBLES-1:0]   result_o,
  output logic                          cout_o,
  output logic                          ovf_o
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            op_q, op_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_cout;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  addsub_nibble u_nibble (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .m_i    (op_q),
    .cin_i  (carry_q),
    .s_o    (nib_s),
    .cout_o (nib_cout)
  );

  // Next-state: capture in idle, one nibble per run cycle, single-cycle done.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          a_d      = a_i;
          b_d      = b_i;
          op_d     = op_i;
          idx_d    = '0;
          carry_d  = op_i;  // subtract = a + ~b + 1
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      StRun: begin
        result_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_cout;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
          cout_d  = nib_cout;
          // Overflow: effective operands share a sign that the sum does not.
          ovf_d   = (a_q[W-1] == (b_q[W-1] ^ op_q)) && (nib_s[NIBBLE_W-1] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status decoded straight from the state register; no input-to-output path.
  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q == StRun);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl with NIBBLES=4 and hand-computed expectations.
module tb_serial_addsub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .cout_o   (cout),
    .ovf_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from idle and wait for done. edges = number of clock
  // edges from the one that samples start to the one that samples done high.
  task automatic do_op(input logic op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                       input bit inject, output int edges, output int busy_cnt,
                       output bit got);
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    tick();
    start    = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got   = 1'b1;
        edges = k + 1;
        break;
      end
      if (inject && k == 1) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
      end
      if (inject && k == 2) start = 1'b0;
      tick();
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    bit          inject;
  } vec_t;

  vec_t vecs[5] = '{
    '{"add_1234_0fcd", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0},
    '{"sub_5_7",       1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0},
    '{"add_7fff_1",    1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{"sub_8000_1",    1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0},
    '{"add_ffff_1",    1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1}
  };

  initial begin
    int  edges;
    int  busy_cnt;
    bit  got;
    int  done_cnt;

    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout",   32'(cout),   32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inject, edges, busy_cnt, got);
      check({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].res));
      check({vecs[i].name, "_cout"},   32'(cout),   32'(vecs[i].cout));
      check({vecs[i].name, "_ovf"},    32'(ovf),    32'(vecs[i].ovf));
      if (i == 0) begin
        check("latency_edges", 32'(edges),    32'd5);
        check("busy_cycles",   32'(busy_cnt), 32'd4);
      end
      tick();
      check({vecs[i].name, "_done_pulse"}, 32'(done),  32'd0);
      check({vecs[i].name, "_ready_back"}, 32'(ready), 32'd1);
      check({vecs[i].name, "_hold"},       32'(result), 32'(vecs[i].res));
    end

    // Reset in the second run cycle aborts the operation.
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h00FF;
    b     = 16'h0001;
    tick();
    start = 1'b0;
    check("abort_busy_run1", 32'(busy), 32'd1);
    tick();
    check("abort_busy_run2", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready",  32'(ready),  32'd1);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Reset and start together: request must not be captured.
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h0003;
    b     = 16'h0004;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_ready", 32'(ready), 32'd1);
    check("rst_start_busy",  32'(busy),  32'd0);
    tick();
    check("rst_start_idle",  32'(busy),  32'd0);

    do_op(1'b0, 16'h0001, 16'h0001, 1'b0, edges, busy_cnt, got);
    check("after_abort_result", 32'(result), 32'h0002);
    check("after_abort_cout",   32'(cout),   32'd0);
    check("after_abort_ovf",    32'(ovf),    32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
